btb_train_gen: RTL

//  Producer side of the BTB training port (br_commit_/jump_commit_/com_addr/com_tar_addr).

---
 rtl/btb_train_pkg.sv | 26 ++
 rtl/btb_train_gen_miss_chk.sv | 27 ++
 rtl/btb_train_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/btb_train_pkg.sv
// Shared types for the BTB training generator: queue index and entry layout.
package btb_train_pkg;

    localparam int BTB_ADDR_W    = 32;
    localparam int BRQ_D_DEFAULT = 8;
    localparam int BRQ_IDX_W     = $clog2(BRQ_D_DEFAULT);

    typedef logic [BRQ_IDX_W-1:0]  BrqIdx_t;
    typedef logic [BTB_ADDR_W-1:0] btb_addr_t;

    typedef struct packed {
        logic      valid;
        logic      resolved;
        logic      jump;
        btb_addr_t pc;
        logic      pred_hit;
        btb_addr_t pred_tar;
        logic      taken;
        btb_addr_t tar;
    } brq_entry_t;

    function automatic btb_addr_t seq_pc(input btb_addr_t pc);
        return pc + btb_addr_t'(4);
    endfunction

endpackage

// File: rtl/btb_train_gen_miss_chk.sv
// Combinational mispredict verdict for one resolved control-flow entry.
module btb_miss_chk #(
    parameter int ADDR = 32
) (
    input  logic            jump,
    input  logic            pred_hit,
    input  logic [ADDR-1:0] pred_tar,
    input  logic            taken,
    input  logic [ADDR-1:0] tar,
    output logic            miss
);

    logic tar_ne;

    assign tar_ne = (pred_tar != tar);

    always_comb begin
        miss = 1'b0;
        if (jump) begin
            miss = !pred_hit || tar_ne;
        end else begin
            // a target compare only matters when both sides say taken
            miss = (pred_hit != taken) || (pred_hit && taken && tar_ne);
        end
    end

endmodule

// File: rtl/btb_train_gen.sv
// In-order branch queue producing one-cycle BTB training pulses on retire.
// Define BTB_TRAIN_STAT_EN to add saturating commit/miss counters.
module btb_train_gen
    import btb_train_pkg::*;
#(
    parameter int ADDR  = BTB_ADDR_W,
    parameter int BRQ_D = BRQ_D_DEFAULT,
    localparam int IDX  = $clog2(BRQ_D)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_valid_,
    input  logic            fetch_jump_,
    input  logic [ADDR-1:0] fetch_pc,
    input  logic            pred_hit,
    input  logic [ADDR-1:0] pred_tar,
    output logic [IDX-1:0]  fetch_idx,
    output logic            brq_full,
    input  logic            res_valid_,
    input  logic [IDX-1:0]  res_idx,
    input  logic            res_taken_,
    input  logic [ADDR-1:0] res_tar,
    output logic            head_ready,
    input  logic            retire_,
    input  logic            flush_,
`ifdef BTB_TRAIN_STAT_EN
    output logic [31:0]     stat_com_cnt,
    output logic [31:0]     stat_miss_cnt,
`endif
    output logic            br_commit_,
    output logic            br_taken_,
    output logic            br_miss_,
    output logic            jump_commit_,
    output logic            jump_miss_,
    output logic [ADDR-1:0] com_addr,
    output logic [ADDR-1:0] com_tar_addr
);

    brq_entry_t     brq   [BRQ_D];
    brq_entry_t     brq_d [BRQ_D];
    logic [IDX-1:0] head;
    logic [IDX-1:0] tail;
    logic [IDX-1:0] head_d;
    logic [IDX-1:0] tail_d;
    logic           head_ready_q;
    logic           head_ready_d;

    logic alloc;
    logic resolve;
    logic retire;
    logic flush;
    logic head_miss;

    assign brq_full   = brq[tail].valid;
    assign fetch_idx  = tail;
    assign head_ready = head_ready_q;

    assign alloc   = !fetch_valid_ && !brq_full;
    assign resolve = !res_valid_ && brq[res_idx].valid;
    assign retire  = !retire_ && head_ready_q;
    assign flush   = !flush_;

    always_comb begin
        brq_d = brq;
        if (alloc) begin
            brq_d[tail].valid    = 1'b1;
            brq_d[tail].resolved = 1'b0;
            brq_d[tail].jump     = !fetch_jump_;
            brq_d[tail].pc       = fetch_pc;
            brq_d[tail].pred_hit = pred_hit;
            brq_d[tail].pred_tar = pred_tar;
            brq_d[tail].taken    = 1'b0;
            brq_d[tail].tar      = '0;
        end
        if (resolve) begin
            brq_d[res_idx].resolved = 1'b1;
            brq_d[res_idx].taken    = !res_taken_;
            brq_d[res_idx].tar      = res_tar;
        end
        if (retire) begin
            brq_d[head].valid    = 1'b0;
            brq_d[head].resolved = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < BRQ_D; i++) begin
                brq_d[i].valid    = 1'b0;
                brq_d[i].resolved = 1'b0;
            end
        end
    end

    assign head_d = flush ? '0 : head + IDX'(retire);
    assign tail_d = flush ? '0 : tail + IDX'(alloc);

    // ready is looked up in the next-state image so a resolve lands one cycle later
    assign head_ready_d = brq_d[head_d].valid && brq_d[head_d].resolved;

    btb_miss_chk #(
        .ADDR     (ADDR)
    ) u_miss_chk (
        .jump     (brq[head].jump),
        .pred_hit (brq[head].pred_hit),
        .pred_tar (brq[head].pred_tar),
        .taken    (brq[head].taken),
        .tar      (brq[head].tar),
        .miss     (head_miss)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BRQ_D; i++) begin
                brq[i] <= '0;
            end
            head         <= '0;
            tail         <= '0;
            head_ready_q <= 1'b0;
            br_commit_   <= 1'b1;
            br_taken_    <= 1'b1;
            br_miss_     <= 1'b1;
            jump_commit_ <= 1'b1;
            jump_miss_   <= 1'b1;
            com_addr     <= '0;
            com_tar_addr <= '0;
        end else begin
            brq          <= brq_d;
            head         <= head_d;
            tail         <= tail_d;
            head_ready_q <= head_ready_d;
            br_commit_   <= 1'b1;
            br_taken_    <= 1'b1;
            br_miss_     <= 1'b1;
            jump_commit_ <= 1'b1;
            jump_miss_   <= 1'b1;
            if (retire) begin
                if (brq[head].jump) begin
                    jump_commit_ <= 1'b0;
                    jump_miss_   <= !head_miss;
                end else begin
                    br_commit_ <= 1'b0;
                    br_taken_  <= !brq[head].taken;
                    br_miss_   <= !head_miss;
                end
                com_addr <= brq[head].pc;
                if (brq[head].jump || brq[head].taken) begin
                    com_tar_addr <= brq[head].tar;
                end else begin
                    com_tar_addr <= seq_pc(brq[head].pc);
                end
            end
        end
    end

`ifdef BTB_TRAIN_STAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_com_cnt  <= '0;
            stat_miss_cnt <= '0;
        end else if (retire) begin
            if (stat_com_cnt != '1) begin
                stat_com_cnt <= stat_com_cnt + 32'd1;
            end
            if (head_miss && stat_miss_cnt != '1) begin
                stat_miss_cnt <= stat_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
